// File: rtl/fpnew_result_fifo.sv
// Result buffer between the FPU output handshake and its consumer; replays beats in order.
// Define FPNEW_RESULT_FIFO_FFLAGS_EN to add sticky fflags accumulation (fflags_clr_i/fflags_o).
module fpnew_result_fifo #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned TAG_WIDTH = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [WIDTH-1:0]             result_i,
    input  logic [4:0]                   status_i,
    input  logic [TAG_WIDTH-1:0]         tag_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [WIDTH-1:0]             result_o,
    output logic [4:0]                   status_o,
    output logic [TAG_WIDTH-1:0]         tag_o,
`ifdef FPNEW_RESULT_FIFO_FFLAGS_EN
    input  logic                         fflags_clr_i,
    output logic [4:0]                   fflags_o,
`endif
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH+1);

    logic [WIDTH-1:0]     r_result [DEPTH];
    logic [4:0]           r_status [DEPTH];
    logic [TAG_WIDTH-1:0] r_tag    [DEPTH];
    logic [PtrW-1:0]      r_wp;
    logic [PtrW-1:0]      r_rp;
    logic [CntW-1:0]      r_cnt;

    logic w_push;
    logic w_pop;

    // Ready is decided from occupancy alone, so a full buffer stalls even during a pop.
    assign in_ready_o  = !rst_i && (r_cnt != CntW'(DEPTH));
    assign out_valid_o = (r_cnt != '0);
    assign w_push      = in_valid_i && in_ready_o;
    assign w_pop       = out_valid_o && out_ready_i;
    assign count_o     = r_cnt;

    assign result_o = out_valid_o ? r_result[r_rp] : '0;
    assign status_o = out_valid_o ? r_status[r_rp] : '0;
    assign tag_o    = out_valid_o ? r_tag[r_rp]    : '0;

    always_ff @(posedge clk_i) begin
        if (w_push && !flush_i) begin
            r_result[r_wp] <= result_i;
            r_status[r_wp] <= status_i;
            r_tag[r_wp]    <= tag_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + PtrW'(1);
            end
            if (w_pop) begin
                r_rp <= r_rp + PtrW'(1);
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + CntW'(1);
            end else if (w_pop && !w_push) begin
                r_cnt <= r_cnt - CntW'(1);
            end
        end
    end

`ifdef FPNEW_RESULT_FIFO_FFLAGS_EN
    logic [4:0] r_fflags;

    // A clear in the same cycle as a push keeps that push's status; flushed pushes do not count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_fflags <= '0;
        end else if (w_push && !flush_i) begin
            r_fflags <= (fflags_clr_i ? 5'd0 : r_fflags) | status_i;
        end else if (fflags_clr_i) begin
            r_fflags <= '0;
        end
    end

    assign fflags_o = r_fflags;
`endif

endmodule
